// File: rtl/tdt_dtm_apbm_ctrl_if.sv
// DMI-to-APB bridge bundle: the DMI request/response handshake and the APB
// master bus, grouped so the controller and its environment share one port.
// The controller takes the master view; the slave view is the environment
// (DMI requester plus APB completer).
interface tdt_dtm_apbm_ctrl_if #(
  parameter int DTM_ABITS = 16
);
  // DMI request side
  logic                 dtm_apbm_wr_vld;
  logic [DTM_ABITS-1:0] dtm_apbm_wr_addr;
  logic [1:0]           dtm_apbm_wr_flg;
  logic [31:0]          dtm_apbm_wdata;
  // DMI completion side
  logic [31:0]          apbm_dtm_rdata;
  logic                 apbm_dtm_wr_ready;
  logic                 apbm_dtm_err;
  // APB bus
  logic [DTM_ABITS+1:0] paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
    output apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
    input  apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/tdt_dtm_apbm_ctrl.sv
// DMI-to-APB master controller. Turns a one-cycle DMI request pulse into a
// single APB read or write (SETUP then ACCESS), bounds the ACCESS wait with a
// timeout, and returns a one-cycle completion pulse with data and error flag.
// Every output comes straight from a flop; requests arriving while busy are
// dropped.
module tdt_dtm_apbm_ctrl #(
  parameter int DTM_ABITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  tclk,
  input logic                  trst_b,
  tdt_dtm_apbm_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_nxt;
  logic                 req_accept;
  logic                 access_exit;
  logic                 access_fail;
  logic [7:0]           wait_cnt_q;

  logic [DTM_ABITS+1:0] paddr_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [31:0]          pwdata_q;
  logic [31:0]          rdata_q;
  logic                 ready_q;
  logic                 err_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state plus the decode flags shared with the datapath.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    req_accept  = 1'b0;
    access_exit = 1'b0;
    access_fail = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dtm_apbm_wr_vld &&
            (bus.dtm_apbm_wr_flg == 2'b01 || bus.dtm_apbm_wr_flg == 2'b10)) begin
          req_accept = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        // pready wins over a timeout landing on the same cycle
        if (bus.pready) begin
          access_exit = 1'b1;
          access_fail = bus.pslverr;
          state_nxt   = DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          access_exit = 1'b1;
          access_fail = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ACCESS wait counter: cleared on entry, counts cycles without pready.
  // Abort happens at WAIT_LAST, so the 8-bit count never wraps.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ACCESS && !bus.pready && wait_cnt_q != WAIT_LAST) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // APB control strobes, registered from the next state.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      psel_q    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable_q <= (state_nxt == ACCESS);
    end
  end

  // Request fields latch only on acceptance and hold for the whole transfer.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (req_accept) begin
      paddr_q  <= {bus.dtm_apbm_wr_addr, 2'b00};
      pwrite_q <= bus.dtm_apbm_wr_flg[1];
      pwdata_q <= bus.dtm_apbm_wr_flg[1] ? bus.dtm_apbm_wdata : 32'd0;
    end
  end

  // Completion: one-cycle ready/err pulse; rdata holds until the next completion.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_nxt == DONE);
      err_q   <= access_exit && access_fail;
      if (access_exit) begin
        if (access_fail) begin
          rdata_q <= 32'd0;
        end else if (!pwrite_q) begin
          rdata_q <= bus.prdata;
        end
      end
    end
  end

  assign bus.paddr             = paddr_q;
  assign bus.psel              = psel_q;
  assign bus.penable           = penable_q;
  assign bus.pwrite            = pwrite_q;
  assign bus.pwdata            = pwdata_q;
  assign bus.apbm_dtm_rdata    = rdata_q;
  assign bus.apbm_dtm_wr_ready = ready_q;
  assign bus.apbm_dtm_err      = err_q;

endmodule

// File: tb/tb_tdt_dtm_apbm_ctrl.sv
// Bench for the DMI-to-APB controller: directed scenarios plus randomized
// transactions, each predicted from the transfer rules (cycle counts, error
// and data outcome) and compared cycle by cycle.
module tb_tdt_dtm_apbm_ctrl;

  localparam int ABITS = 16;
  localparam int TO    = 4;

  logic tclk   = 1'b0;
  logic trst_b = 1'b0;

  int          checks    = 0;
  int          errors    = 0;
  logic [31:0] exp_rdata = 32'd0;

  tdt_dtm_apbm_ctrl_if #(.DTM_ABITS(ABITS)) bus ();

  tdt_dtm_apbm_ctrl #(
    .DTM_ABITS      (ABITS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .tclk   (tclk),
    .trst_b (trst_b),
    .bus    (bus)
  );

  always #5 tclk = ~tclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_psel"},  32'(bus.psel),              32'd0);
    check({tag, "_pen"},   32'(bus.penable),           32'd0);
    check({tag, "_ready"}, 32'(bus.apbm_dtm_wr_ready), 32'd0);
    check({tag, "_err"},   32'(bus.apbm_dtm_err),      32'd0);
    check({tag, "_rdata"}, bus.apbm_dtm_rdata,         exp_rdata);
  endtask

  // One DMI transaction. Called at a falling edge with the block idle; returns
  // at the falling edge of the idle cycle after the ready pulse.
  task automatic do_txn(input logic [1:0] flg, input logic [ABITS-1:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic slverr, input logic [31:0] sdata, input bit inject);
    logic [31:0] e_paddr, e_pwdata, e_rdata;
    logic        e_pwrite, e_err;
    bit          tmo;
    int          acc;
    e_paddr  = 32'({addr, 2'b00});
    e_pwrite = flg[1];
    e_pwdata = flg[1] ? wdata : 32'd0;
    tmo      = (waits >= TO);
    acc      = tmo ? TO : waits + 1;
    e_err    = tmo || slverr;
    e_rdata  = e_err ? 32'd0 : (flg[1] ? exp_rdata : sdata);

    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = flg;
    bus.dtm_apbm_wr_addr = addr;
    bus.dtm_apbm_wdata   = wdata;
    @(negedge tclk);
    // scramble the request fields: the latched copies must not follow them
    bus.dtm_apbm_wr_vld  = 1'b0;
    bus.dtm_apbm_wr_addr = ABITS'($urandom);
    bus.dtm_apbm_wdata   = $urandom;
    check("setup_psel",  32'(bus.psel),              32'd1);
    check("setup_pen",   32'(bus.penable),           32'd0);
    check("setup_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
    check("setup_paddr", 32'(bus.paddr),             e_paddr);
    check("setup_pwr",   32'(bus.pwrite),            32'(e_pwrite));
    check("setup_pwd",   bus.pwdata,                 e_pwdata);

    for (int k = 0; k < acc; k++) begin
      @(negedge tclk);
      bus.dtm_apbm_wr_vld = 1'b0;
      check("acc_psel",  32'(bus.psel),              32'd1);
      check("acc_pen",   32'(bus.penable),           32'd1);
      check("acc_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
      check("acc_paddr", 32'(bus.paddr),             e_paddr);
      check("acc_pwr",   32'(bus.pwrite),            32'(e_pwrite));
      check("acc_pwd",   bus.pwdata,                 e_pwdata);
      bus.pready  = (k == waits);
      bus.pslverr = (k == waits) ? slverr : 1'($urandom);
      bus.prdata  = (k == waits) ? sdata : $urandom;
      if (inject && k == 0) begin
        bus.dtm_apbm_wr_vld  = 1'b1;
        bus.dtm_apbm_wr_flg  = ($urandom % 2 == 0) ? 2'b01 : 2'b10;
        bus.dtm_apbm_wr_addr = ABITS'($urandom);
        bus.dtm_apbm_wdata   = $urandom;
      end
    end

    @(negedge tclk);
    bus.dtm_apbm_wr_vld = 1'b0;
    bus.pready          = 1'b0;
    bus.pslverr         = 1'b0;
    exp_rdata           = e_rdata;
    check("done_ready", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    check("done_err",   32'(bus.apbm_dtm_err),      32'(e_err));
    check("done_rdata", bus.apbm_dtm_rdata,         exp_rdata);
    check("done_psel",  32'(bus.psel),              32'd0);
    check("done_pen",   32'(bus.penable),           32'd0);

    @(negedge tclk);
    check_quiet("post");
  endtask

  // A request pulse that must be ignored entirely.
  task automatic do_noop(input logic [1:0] flg);
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = flg;
    bus.dtm_apbm_wr_addr = ABITS'($urandom);
    bus.dtm_apbm_wdata   = $urandom;
    @(negedge tclk);
    bus.dtm_apbm_wr_vld = 1'b0;
    check_quiet("noop1");
    @(negedge tclk);
    check_quiet("noop2");
  endtask

  initial begin
    bus.dtm_apbm_wr_vld  = 1'b0;
    bus.dtm_apbm_wr_addr = '0;
    bus.dtm_apbm_wr_flg  = 2'b00;
    bus.dtm_apbm_wdata   = '0;
    bus.prdata           = '0;
    bus.pready           = 1'b0;
    bus.pslverr          = 1'b0;

    // reset state
    repeat (2) @(negedge tclk);
    check_quiet("rst");
    check("rst_paddr", 32'(bus.paddr),  32'd0);
    check("rst_pwr",   32'(bus.pwrite), 32'd0);
    check("rst_pwd",   bus.pwdata,      32'd0);
    trst_b = 1'b1;
    @(negedge tclk);

    // zero-wait read, then 3-wait write with rdata unchanged
    do_txn(2'b01, 16'h0011, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    do_txn(2'b10, 16'h0010, 32'h00000001, 3, 1'b0, 32'h12345678, 1'b0);
    // slave error, then a clean read
    do_txn(2'b01, 16'h0020, 32'h0, 0, 1'b1, 32'hCAFEF00D, 1'b0);
    do_txn(2'b01, 16'h0021, 32'h0, 1, 1'b0, 32'h0BADC0DE, 1'b0);
    // timeout, pready on the last allowed cycle, and a write that times out
    do_txn(2'b01, 16'h0030, 32'h0, TO, 1'b0, 32'h11111111, 1'b0);
    do_txn(2'b01, 16'h0031, 32'h0, TO - 1, 1'b0, 32'h22222222, 1'b0);
    do_txn(2'b10, 16'hFFFF, 32'hA5A5A5A5, TO + 1, 1'b0, 32'h0, 1'b0);
    // ignored pulses: no-op opcodes and a request during ACCESS
    do_noop(2'b00);
    do_noop(2'b11);
    do_txn(2'b01, 16'h0040, 32'h0, 2, 1'b0, 32'h33333333, 1'b1);

    // asynchronous reset during ACCESS
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = 2'b01;
    bus.dtm_apbm_wr_addr = 16'h0050;
    @(negedge tclk);
    bus.dtm_apbm_wr_vld = 1'b0;
    @(negedge tclk);
    #2 trst_b = 1'b0;
    #1;
    exp_rdata = 32'd0;
    check_quiet("arst");
    @(negedge tclk);
    trst_b = 1'b1;
    @(negedge tclk);
    check_quiet("arst_rel");
    do_txn(2'b01, 16'h0051, 32'h0, 0, 1'b0, 32'h44444444, 1'b0);

    // randomized back-to-back traffic
    for (int i = 0; i < 30; i++) begin
      if ($urandom % 6 == 0) begin
        do_noop(($urandom % 2 == 0) ? 2'b00 : 2'b11);
      end else begin
        do_txn(($urandom % 2 == 0) ? 2'b01 : 2'b10, ABITS'($urandom), $urandom,
               int'($urandom_range(0, TO + 1)), ($urandom % 4 == 0),
               $urandom, ($urandom % 3 == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
